regfile_32x32: RTL and testbench
================================

# regfile_32x32

Thirty-two-entry, Q-bit register file with one synchronous write port and two combinational read ports. Its write side is a 5-to-32 one-hot decoder that steers a single write into one of 32 registers; the read ports select a register through `mux_32to1`. It serves as the architectural register file of the lab CPU datapath, and register 0 is hardwired to zero.

## Interface
Parameters:
- `Q`, default 32: data width of every register and data port.

Ports:
- `clk` in, 1: the single clock. All state updates on the rising edge.
- `rst` in, 1: reset, synchronous and active-high.
- `wr_ena` in, 1: write enable, sampled at the rising edge of `clk`.
- `wr_addr` in, 5: write register index.
- `wr_data` in, Q: write data.
- `rd_addr0` in, 5: read port 0 index.
- `rd_data0` out, Q: read port 0 data.
- `rd_addr1` in, 5: read port 1 index.
- `rd_data1` out, Q: read port 1 data.
- `wr_onehot` out, 32: registered one-hot copy of the last accepted write strobe, for debug and verification.

## Operation
- Decoder:
  - Produces `dec[i] = wr_ena & (wr_addr == i)` for i = 0..31.
  - Exactly one bit is high when `wr_ena` is 1, and all bits are low otherwise.
- Registers 1..31:
  - At each rising edge, `reg[i] <= wr_data` when `dec[i]`.
  - Otherwise each register holds its value.
- Register 0:
  - Always reads as 0.
  - A write to index 0 is accepted by the decoder but discarded; no storage is updated.
- Read ports:
  - Purely combinational: `rd_dataN = reg[rd_addrN]`, where index 0 returns 0.
  - Both ports are independent, and they may address the same register.
- `wr_onehot`:
  - Loads `dec` at every rising edge, including the cycle where `wr_ena` = 0, which loads all zeros.
  - Bit 0 still reports a discarded write to index 0.
- Reset:
  - When `rst` = 1 at a rising edge, all registers and `wr_onehot` clear to 0.
  - Reset takes priority over a simultaneous write, so the write is lost.
- No read/write bypass:
  - A read of the address being written in the same cycle returns the old value.
  - The new value is visible after the edge.

## Timing
- Write latency: data is visible on the read ports one clock after the edge that samples `wr_ena` = 1.
- Read latency: zero cycles, combinational from `rd_addrN` and register state.
- Reset values:
  - All `reg[i]` = 0, so `rd_data0` = `rd_data1` = 0 for every address.
  - `wr_onehot` = 0.
- Reset mid-operation: reset overrides any in-flight write on that edge. The first write can be accepted on the first edge with `rst` = 0.
- Back-to-back writes to the same address:
  - The last write wins.
  - Each write is visible for exactly the cycle after its edge until overwritten.
- Out-of-range addresses are impossible because 5-bit indices span exactly 32 entries.
- Inputs sampled on `clk` must be stable for setup/hold around the rising edge. Read addresses have no timing constraint beyond combinational path delay.

## Structure
- Shared constants belong in the team's common defines file:
  - `REG_COUNT` = 32.
  - `REG_ADDR_W` = 5.
  - `REG_ZERO` = 5'd0.
- Sub-module `decoder_5to32`:
  - Ports: `ena`, `A[4:0]`, `Z[31:0]`.
  - Purely combinational; it is the write-side counterpart of the read mux.
- Read ports: two instances of the existing `mux_32to1` with `#(.Q(Q))`. The A..P inputs take `reg[0..15]`, and the AA..PP inputs take `reg[16..31]`.
- Storage: registers 1..31 in one generate loop, each with its own enable `dec[i]`. Register 0 is tied to constant 0.

## Test plan
- Reset check:
  - Stimulus: assert `rst` for 2 cycles with `wr_ena` = 1, `wr_addr` = 5, `wr_data` = 32'hDEADBEEF.
  - Response: afterwards all 32 addresses read 0 on both ports, and `wr_onehot` = 0.
- Write then read:
  - Stimulus: write 32'h0000_0001 to r1 and 32'hFFFF_FFFF to r31.
  - Response: next cycle `rd_addr0` = 1 gives 1, and `rd_addr1` = 31 gives 32'hFFFF_FFFF. `wr_onehot` shows bit 1, then bit 31.
- Register zero:
  - Stimulus: write 32'h1234_5678 to r0.
  - Response: `rd_data0` at address 0 stays 0, and `wr_onehot` = 32'h0000_0001.
- Same-cycle read/write:
  - Stimulus: r7 holds 32'hA; write 32'hB to r7 while `rd_addr0` = 7.
  - Response: `rd_data0` = 32'hA before the edge and 32'hB after it.
- Disabled write:
  - Stimulus: `wr_ena` = 0, `wr_addr` = 3, `wr_data` = 32'h55.
  - Response: r3 is unchanged and `wr_onehot` = 0.
- Full sweep:
  - Stimulus: write value i+100 to every address i = 0..31 on consecutive cycles, then read all addresses on both ports.
  - Response: every address i ≥ 1 reads i+100, and address 0 reads 0.
  - Stimulus: assert `rst` during cycle 16 of the sweep.
  - Response: only writes after the reset are retained.

Source files
------------

// File: rtl/regfile_32x32_pkg.sv
// Purpose: shared constants for the 32-entry register file and its decode/mux helpers.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package regfile_32x32_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : regfile_32x32_pkg

// File: rtl/regfile_32x32_if.sv
// Purpose: bundles the register-file write port, both read ports and the debug strobe.
// Latency: n/a (wiring only).
// Backpressure: none; writes are always accepted and reads always return data.
// Ports: master drives wr_ena/wr_addr/wr_data/rd_addr0/rd_addr1 and observes
//        rd_data0/rd_data1/wr_onehot; slave is the register file side.
interface regfile_32x32_if
    import regfile_32x32_pkg::*;
#(
    parameter int Q = 32
);
    logic                  wr_ena;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [Q-1:0]          wr_data;
    logic [REG_ADDR_W-1:0] rd_addr0;
    logic [Q-1:0]          rd_data0;
    logic [REG_ADDR_W-1:0] rd_addr1;
    logic [Q-1:0]          rd_data1;
    logic [REG_COUNT-1:0]  wr_onehot;

    modport master (
        output wr_ena,
        output wr_addr,
        output wr_data,
        output rd_addr0,
        output rd_addr1,
        input  rd_data0,
        input  rd_data1,
        input  wr_onehot
    );

    modport slave (
        input  wr_ena,
        input  wr_addr,
        input  wr_data,
        input  rd_addr0,
        input  rd_addr1,
        output rd_data0,
        output rd_data1,
        output wr_onehot
    );

endinterface : regfile_32x32_if

// File: rtl/regfile_32x32_dec.sv
// Purpose: 5-to-32 one-hot write decoder, write-side counterpart of the read mux.
// Latency: combinational.
// Backpressure: none.
// Ports: ena (enable), A[4:0] (index), Z[31:0] (one-hot strobe, all zero when ena=0).
module decoder_5to32
    import regfile_32x32_pkg::*;
(
    input  logic                  ena,
    input  logic [REG_ADDR_W-1:0] A,
    output logic [REG_COUNT-1:0]  Z
);

    always_comb begin
        Z = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            Z[i] = ena & (A == REG_ADDR_W'(i));
        end
    end

endmodule : decoder_5to32

// File: rtl/regfile_32x32_mux.sv
// Purpose: 32-to-1 Q-bit read multiplexer; A..P carry entries 0..15, AA..PP entries 16..31.
// Latency: combinational.
// Backpressure: none.
// Ports: A..P, AA..PP (data inputs), S[4:0] (select), Z (selected data).
module mux_32to1
    import regfile_32x32_pkg::*;
#(
    parameter int Q = 32
) (
    input  logic [Q-1:0]          A,  B,  C,  D,  E,  F,  G,  H,
    input  logic [Q-1:0]          I,  J,  K,  L,  M,  N,  O,  P,
    input  logic [Q-1:0]          AA, BB, CC, DD, EE, FF, GG, HH,
    input  logic [Q-1:0]          II, JJ, KK, LL, MM, NN, OO, PP,
    input  logic [REG_ADDR_W-1:0] S,
    output logic [Q-1:0]          Z
);

    always_comb begin
        Z = '0;
        unique case (S)
            5'd0:  Z = A;
            5'd1:  Z = B;
            5'd2:  Z = C;
            5'd3:  Z = D;
            5'd4:  Z = E;
            5'd5:  Z = F;
            5'd6:  Z = G;
            5'd7:  Z = H;
            5'd8:  Z = I;
            5'd9:  Z = J;
            5'd10: Z = K;
            5'd11: Z = L;
            5'd12: Z = M;
            5'd13: Z = N;
            5'd14: Z = O;
            5'd15: Z = P;
            5'd16: Z = AA;
            5'd17: Z = BB;
            5'd18: Z = CC;
            5'd19: Z = DD;
            5'd20: Z = EE;
            5'd21: Z = FF;
            5'd22: Z = GG;
            5'd23: Z = HH;
            5'd24: Z = II;
            5'd25: Z = JJ;
            5'd26: Z = KK;
            5'd27: Z = LL;
            5'd28: Z = MM;
            5'd29: Z = NN;
            5'd30: Z = OO;
            5'd31: Z = PP;
            default: Z = '0;
        endcase
    end

endmodule : mux_32to1

// File: rtl/regfile_32x32.sv
// Purpose: 32 x Q architectural register file, one synchronous write, two combinational reads, r0 = 0.
// Latency: write visible one clock after the sampling edge; reads are zero-cycle, no write bypass.
// Backpressure: none; every write is accepted (writes to r0 are decoded then discarded).
// Ports: clk, rst (sync, active-high), bus (slave modport: write port, two read ports,
//        wr_onehot = registered copy of the write strobe).
module regfile_32x32
    import regfile_32x32_pkg::*;
#(
    parameter int Q = 32
) (
    input  logic           clk,
    input  logic           rst,
    regfile_32x32_if.slave bus
);

    logic [REG_COUNT-1:0] dec;
    logic [REG_COUNT-1:0] wr_onehot_d;
    logic [REG_COUNT-1:0] wr_onehot_q;
    logic [Q-1:0]         reg_val [REG_COUNT];

    decoder_5to32 u_dec (
        .ena (bus.wr_ena),
        .A   (bus.wr_addr),
        .Z   (dec)
    );

    // r0 has no storage; dec[0] only reaches the debug strobe.
    assign reg_val[REG_ZERO] = '0;

    for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_reg
        logic [Q-1:0] r_d;
        logic [Q-1:0] r_q;

        always_comb begin
            r_d = r_q;
            if (dec[gi]) begin
                r_d = bus.wr_data;
            end
        end

        // Reset wins over a write landing on the same edge.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else begin
                r_q <= r_d;
            end
        end

        assign reg_val[gi] = r_q;
    end

    // Loads every cycle, so an idle cycle clears the strobe.
    always_comb begin
        wr_onehot_d = dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_onehot_q <= '0;
        end else begin
            wr_onehot_q <= wr_onehot_d;
        end
    end

    assign bus.wr_onehot = wr_onehot_q;

    mux_32to1 #(.Q(Q)) u_rd_mux0 (
        .A  (reg_val[0]),  .B  (reg_val[1]),  .C  (reg_val[2]),  .D  (reg_val[3]),
        .E  (reg_val[4]),  .F  (reg_val[5]),  .G  (reg_val[6]),  .H  (reg_val[7]),
        .I  (reg_val[8]),  .J  (reg_val[9]),  .K  (reg_val[10]), .L  (reg_val[11]),
        .M  (reg_val[12]), .N  (reg_val[13]), .O  (reg_val[14]), .P  (reg_val[15]),
        .AA (reg_val[16]), .BB (reg_val[17]), .CC (reg_val[18]), .DD (reg_val[19]),
        .EE (reg_val[20]), .FF (reg_val[21]), .GG (reg_val[22]), .HH (reg_val[23]),
        .II (reg_val[24]), .JJ (reg_val[25]), .KK (reg_val[26]), .LL (reg_val[27]),
        .MM (reg_val[28]), .NN (reg_val[29]), .OO (reg_val[30]), .PP (reg_val[31]),
        .S  (bus.rd_addr0),
        .Z  (bus.rd_data0)
    );

    mux_32to1 #(.Q(Q)) u_rd_mux1 (
        .A  (reg_val[0]),  .B  (reg_val[1]),  .C  (reg_val[2]),  .D  (reg_val[3]),
        .E  (reg_val[4]),  .F  (reg_val[5]),  .G  (reg_val[6]),  .H  (reg_val[7]),
        .I  (reg_val[8]),  .J  (reg_val[9]),  .K  (reg_val[10]), .L  (reg_val[11]),
        .M  (reg_val[12]), .N  (reg_val[13]), .O  (reg_val[14]), .P  (reg_val[15]),
        .AA (reg_val[16]), .BB (reg_val[17]), .CC (reg_val[18]), .DD (reg_val[19]),
        .EE (reg_val[20]), .FF (reg_val[21]), .GG (reg_val[22]), .HH (reg_val[23]),
        .II (reg_val[24]), .JJ (reg_val[25]), .KK (reg_val[26]), .LL (reg_val[27]),
        .MM (reg_val[28]), .NN (reg_val[29]), .OO (reg_val[30]), .PP (reg_val[31]),
        .S  (bus.rd_addr1),
        .Z  (bus.rd_data1)
    );

endmodule : regfile_32x32

// File: tb/tb_regfile_32x32.sv
module tb_regfile_32x32;

    logic clk;
    logic rst;

    regfile_32x32_if #(.Q(32)) bus ();

    regfile_32x32 #(.Q(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    typedef struct {
        logic        wr_ena;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [4:0]  rd_addr0;
        logic [4:0]  rd_addr1;
        logic [31:0] exp_rd0;    // before the edge
        logic [31:0] exp_rd1;    // before the edge
        logic [31:0] exp_onehot; // after the edge
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.wr_ena   = en;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.rd_addr0 = ra0;
        bus.rd_addr1 = ra1;
    endtask

    task automatic read_all(input string tag, input int mode);
        // mode 0: all zero; 1: i+100 for i>=1; 2: i+200 for i>=17, else 0
        logic [31:0] exp;
        bus.wr_ena = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr0 = 5'(i);
            bus.rd_addr1 = 5'(31 - i);
            #1;
            if (mode == 1)      exp = (i == 0) ? 32'd0 : 32'(i + 100);
            else if (mode == 2) exp = (i >= 17) ? 32'(i + 200) : 32'd0;
            else                exp = 32'd0;
            check($sformatf("%s rd0[%0d]", tag, i), bus.rd_data0, exp);
            if (mode == 1)      exp = ((31 - i) == 0) ? 32'd0 : 32'(31 - i + 100);
            else if (mode == 2) exp = ((31 - i) >= 17) ? 32'(31 - i + 200) : 32'd0;
            else                exp = 32'd0;
            check($sformatf("%s rd1[%0d]", tag, 31 - i), bus.rd_data1, exp);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1, 5'd31, 32'h0,         32'h0,         32'h0000_0002};
        vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd1, 5'd31, 32'h1,         32'h0,         32'h8000_0000};
        vecs[2] = '{1'b1, 5'd0,  32'h1234_5678, 5'd1, 5'd31, 32'h1,         32'hFFFF_FFFF, 32'h0000_0001};
        vecs[3] = '{1'b1, 5'd7,  32'h0000_000A, 5'd0, 5'd0,  32'h0,         32'h0,         32'h0000_0080};
        vecs[4] = '{1'b1, 5'd7,  32'h0000_000B, 5'd7, 5'd7,  32'hA,         32'hA,         32'h0000_0080};
        vecs[5] = '{1'b0, 5'd3,  32'h0000_0055, 5'd7, 5'd3,  32'hB,         32'h0,         32'h0000_0000};
        vecs[6] = '{1'b0, 5'd3,  32'h0000_0055, 5'd3, 5'd0,  32'h0,         32'h0,         32'h0000_0000};
        vecs[7] = '{1'b1, 5'd3,  32'h0000_CAFE, 5'd31, 5'd1, 32'hFFFF_FFFF, 32'h1,         32'h0000_0008};
        vecs[8] = '{1'b1, 5'd3,  32'h0000_BEEF, 5'd3, 5'd3,  32'hCAFE,      32'hCAFE,      32'h0000_0008};
        vecs[9] = '{1'b0, 5'd0,  32'h0,         5'd3, 5'd7,  32'hBEEF,      32'hB,         32'h0000_0000};

        // Reset held two cycles with a write pending: the write must be lost.
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        tick();
        tick();
        check("reset onehot", bus.wr_onehot, 32'h0);
        rst = 1'b0;
        read_all("reset", 0);

        // Table-driven write/read sequence, state carried from vector to vector.
        for (int v = 0; v < 10; v++) begin
            drive(vecs[v].wr_ena, vecs[v].wr_addr, vecs[v].wr_data, vecs[v].rd_addr0, vecs[v].rd_addr1);
            #1;
            check($sformatf("vec%0d rd0", v), bus.rd_data0, vecs[v].exp_rd0);
            check($sformatf("vec%0d rd1", v), bus.rd_data1, vecs[v].exp_rd1);
            tick();
            check($sformatf("vec%0d onehot", v), bus.wr_onehot, vecs[v].exp_onehot);
        end
        // Back-to-back same address and r0: last write visible, r0 still zero.
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        #1;
        check("last write wins r3", bus.rd_data0, 32'h0000_BEEF);
        check("r0 after write", bus.rd_data1, 32'h0);

        // Full sweep of writes on consecutive cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i + 100), 5'd0, 5'd0);
            tick();
        end
        check("sweep last onehot", bus.wr_onehot, 32'h8000_0000);
        read_all("sweep", 1);

        // Sweep with reset during cycle 16: writes 0..16 are lost.
        for (int i = 0; i < 32; i++) begin
            rst = (i == 16);
            drive(1'b1, 5'(i), 32'(i + 200), 5'd0, 5'd0);
            tick();
            if (i == 16) check("sweep rst onehot", bus.wr_onehot, 32'h0);
            if (i == 17) check("first write after rst onehot", bus.wr_onehot, 32'h0002_0000);
        end
        rst = 1'b0;
        read_all("sweep_rst", 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_32x32
